// File: rtl/mesi_mem_pkg.sv
// Shared definitions for the MESI main-memory responder: FSM states,
// default geometry and latency values, and the latency counter width.
package mesi_mem_pkg;

    localparam int ADDRESSSIZE_DEF    = 32;
    localparam int MEM_DEPTH_LOG2_DEF = 10;
    localparam int RD_LATENCY_DEF     = 4;
    localparam int WR_LATENCY_DEF     = 4;
    localparam int CNT_W              = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_WAIT,
        WR_DONE
    } mem_state_t;

endpackage

// File: rtl/mesi_mem_array.sv
// Word-addressed storage for the main memory: synchronous write,
// combinational read, contents deliberately untouched by reset.
module mesi_mem_array
    import mesi_mem_pkg::*;
#(
    parameter int DATA_W     = ADDRESSSIZE_DEF,
    parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mesi_main_memory.sv
// Main-memory responder on the shared MESI bus: serves BusRd/BusRdX fills
// after a fixed latency and commits Mem_wr write-backs with a done handshake.
module mesi_main_memory
    import mesi_mem_pkg::*;
#(
    parameter int ADDRESSSIZE    = ADDRESSSIZE_DEF,
    parameter int MEM_DEPTH_LOG2 = MEM_DEPTH_LOG2_DEF,
    parameter int RD_LATENCY     = RD_LATENCY_DEF,
    parameter int WR_LATENCY     = WR_LATENCY_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDRESSSIZE-1:0] Address_Com,
    inout  wire  [ADDRESSSIZE-1:0] Data_Bus_Com,
    input  logic                   BusRd,
    input  logic                   BusRdX,
    input  logic                   Mem_wr,
    input  logic                   Mem_oprn_abort,
    output logic                   Data_in_Bus,
    output logic                   Mem_write_done
);

    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LATENCY);
    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mem_state_t                state;
    logic [CNT_W-1:0]          cnt;
    logic [MEM_DEPTH_LOG2-1:0] idx_q;
    logic [ADDRESSSIZE-1:0]    wdata_q;
    logic [ADDRESSSIZE-1:0]    rd_q;
    logic [ADDRESSSIZE-1:0]    arr_rdata;
    logic                      rq;
    logic                      arr_we;
    logic                      unused_addr_hi;

    assign rq = BusRd | BusRdX;

    // Upper address bits alias onto the array; they are intentionally dropped.
    assign unused_addr_hi = ^Address_Com[ADDRESSSIZE-1:MEM_DEPTH_LOG2];

    // Commit lands on the edge where the counter steps 1 -> 0, one edge
    // before Mem_write_done rises; a reset on that edge suppresses it.
    assign arr_we = rst_n && (state == WR_WAIT) && (cnt == CNT_ONE);

    mesi_mem_array #(
        .DATA_W     (ADDRESSSIZE),
        .DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (idx_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            Data_in_Bus    <= 1'b0;
            Mem_write_done <= 1'b0;
            rd_q           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Mem_wr) begin
                        state <= WR_WAIT;
                        cnt   <= WR_CNT;
                    end else if (rq && !Mem_oprn_abort) begin
                        state <= RD_WAIT;
                        cnt   <= RD_CNT;
                    end
                end
                RD_WAIT: begin
                    if (Mem_oprn_abort) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        rd_q        <= arr_rdata;
                        Data_in_Bus <= 1'b1;
                        state       <= RD_DRIVE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RD_DRIVE: begin
                    if (!rq || Mem_oprn_abort) begin
                        Data_in_Bus <= 1'b0;
                        state       <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (cnt == '0) begin
                        Mem_write_done <= 1'b1;
                        state          <= WR_DONE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WR_DONE: begin
                    if (!Mem_wr) begin
                        Mem_write_done <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address and write data are captured only at acceptance; no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && (Mem_wr || rq)) begin
            idx_q <= Address_Com[MEM_DEPTH_LOG2-1:0];
        end
        if (state == IDLE && Mem_wr) begin
            wdata_q <= Data_Bus_Com;
        end
    end

    assign Data_Bus_Com = Data_in_Bus ? rd_q : {ADDRESSSIZE{1'bz}};

endmodule
